// File: rtl/missile_slot_scheduler.sv
// Shared missile-slot pool: collects shooter fire pulses and, once per frame,
// hands out free slots round-robin as one-cycle launch commands.
module missile_slot_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_SLOTS  = 8,
  parameter int SLOT_IDX_W = $clog2(NUM_SLOTS),
  parameter int REQ_IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  startOfFrame,
  input  logic [NUM_REQ-1:0]    fire_req,
  input  logic [NUM_SLOTS-1:0]  slot_release,
  output logic [NUM_REQ-1:0]    grant,
  output logic [SLOT_IDX_W-1:0] grant_slot,
  output logic                  launch,
  output logic [NUM_SLOTS-1:0]  slot_busy,
  output logic [SLOT_IDX_W:0]   free_count,
  output logic                  dbgState,
  output logic [REQ_IDX_W-1:0]  dbgRrPtr
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t               state;
  logic [NUM_REQ-1:0]   pending;
  logic [NUM_REQ-1:0]   served;
  logic [REQ_IDX_W-1:0] rrPtr;

  logic [NUM_REQ-1:0]    cand;
  logic                  winnerFound;
  logic [REQ_IDX_W-1:0]  winnerIdx;
  logic [REQ_IDX_W-1:0]  rrNext;
  logic                  slotFound;
  logic [SLOT_IDX_W-1:0] freeIdx;
  logic                  doGrant;
  logic [NUM_REQ-1:0]    grantVec;
  logic [NUM_REQ-1:0]    pendingNext;
  logic [NUM_SLOTS-1:0]  busyNext;
  logic [SLOT_IDX_W:0]   busyCount;
  int                    probe;

  assign dbgState = (state == SCAN);
  assign dbgRrPtr = rrPtr;

  // Round-robin pick among shooters still waiting and not yet served this frame.
  always_comb begin
    cand        = pending & ~served;
    winnerFound = 1'b0;
    winnerIdx   = '0;
    probe       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      probe = (int'(rrPtr) + k) % NUM_REQ;
      if (!winnerFound && cand[probe]) begin
        winnerFound = 1'b1;
        winnerIdx   = probe[REQ_IDX_W-1:0];
      end
    end
  end

  // Lowest-index free slot: scanning downward leaves the lowest one last.
  always_comb begin
    slotFound = 1'b0;
    freeIdx   = '0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (!slot_busy[k]) begin
        slotFound = 1'b1;
        freeIdx   = SLOT_IDX_W'(k);
      end
    end
  end

  always_comb begin
    doGrant  = (state == SCAN) && winnerFound && slotFound;
    grantVec = '0;
    if (doGrant) grantVec[winnerIdx] = 1'b1;
    if (winnerIdx == REQ_IDX_W'(NUM_REQ - 1)) rrNext = '0;
    else                                      rrNext = winnerIdx + REQ_IDX_W'(1);
  end

  // Releases act on the old occupancy; a grant only ever claims a free slot,
  // so a release and a grant in the same cycle never collide.
  always_comb begin
    busyNext = slot_busy & ~slot_release;
    if (doGrant) busyNext[freeIdx] = 1'b1;
    pendingNext = pending;
    if (doGrant) pendingNext[winnerIdx] = 1'b0;
    pendingNext = pendingNext | fire_req;
  end

  always_comb begin
    busyCount = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      busyCount = busyCount + (SLOT_IDX_W + 1)'(slot_busy[k]);
    end
    free_count = (SLOT_IDX_W + 1)'(NUM_SLOTS) - busyCount;
  end

  // launch/grant/grant_slot are a valid-only strobe: launch=1 marks a valid
  // command for exactly one cycle, there is no ready and no back-pressure.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state      <= IDLE;
      pending    <= '0;
      served     <= '0;
      rrPtr      <= '0;
      slot_busy  <= '0;
      grant      <= '0;
      grant_slot <= '0;
      launch     <= 1'b0;
    end else begin
      pending    <= pendingNext;
      slot_busy  <= busyNext;
      grant      <= grantVec;
      launch     <= doGrant;
      grant_slot <= doGrant ? freeIdx : '0;
      case (state)
        IDLE: begin
          if (startOfFrame) begin
            state  <= SCAN;
            served <= '0;
          end
        end
        SCAN: begin
          if (doGrant) begin
            served[winnerIdx] <= 1'b1;
            rrPtr             <= rrNext;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_missile_slot_scheduler.sv
// Directed bench for missile_slot_scheduler: per-cycle reference model plus
// hand-computed grant logs and literal spot checks.
module tb_missile_slot_scheduler;

  localparam int NR = 4;
  localparam int NS = 8;

  logic          clk = 1'b0;
  logic          resetN;
  logic          startOfFrame;
  logic [NR-1:0] fire_req;
  logic [NS-1:0] slot_release;
  logic [NR-1:0] grant;
  logic [2:0]    grant_slot;
  logic          launch;
  logic [NS-1:0] slot_busy;
  logic [3:0]    free_count;
  logic          dbgState;
  logic [1:0]    dbgRrPtr;

  missile_slot_scheduler dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .fire_req(fire_req), .slot_release(slot_release),
    .grant(grant), .grant_slot(grant_slot), .launch(launch),
    .slot_busy(slot_busy), .free_count(free_count),
    .dbgState(dbgState), .dbgRrPtr(dbgRrPtr)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [6:0] exp_q[$];
  logic [6:0] obs_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  bit         mPend[NR];
  bit         mServ[NR];
  bit         mBusy[NS];
  int         mRr;
  bit         mScan;
  logic [3:0] mGrant;
  logic [2:0] mSlot;
  bit         mLaunch;
  bit         modelOn = 1'b0;

  function automatic logic [7:0] busy_vec();
    logic [7:0] v;
    v = '0;
    for (int k = 0; k < NS; k++) v[k] = mBusy[k];
    return v;
  endfunction

  function automatic int free_slots();
    int n;
    n = NS;
    for (int k = 0; k < NS; k++) if (mBusy[k]) n--;
    return n;
  endfunction

  initial forever begin
    int w, s, idx;
    @(posedge clk);
    if (!resetN) begin
      for (int k = 0; k < NR; k++) begin mPend[k] = 0; mServ[k] = 0; end
      for (int k = 0; k < NS; k++) mBusy[k] = 0;
      mRr = 0; mScan = 0; mGrant = '0; mSlot = '0; mLaunch = 0;
      modelOn = 1'b1;
    end else if (modelOn) begin
      w = -1; s = -1;
      mGrant = '0; mSlot = '0; mLaunch = 0;
      if (!mScan) begin
        if (startOfFrame) begin
          mScan = 1;
          for (int k = 0; k < NR; k++) mServ[k] = 0;
        end
      end else begin
        for (int k = 0; k < NR; k++) begin
          idx = (mRr + k) % NR;
          if (w < 0 && mPend[idx] && !mServ[idx]) w = idx;
        end
        for (int k = 0; k < NS; k++) if (s < 0 && !mBusy[k]) s = k;
        if (w < 0 || s < 0) mScan = 0;
      end
      for (int k = 0; k < NS; k++) if (slot_release[k]) mBusy[k] = 0;
      if (mScan && w >= 0 && s >= 0) begin
        mGrant[w] = 1'b1; mLaunch = 1; mSlot = s[2:0];
        mBusy[s] = 1; mServ[w] = 1; mPend[w] = 0; mRr = (w + 1) % NR;
      end
      for (int k = 0; k < NR; k++) if (fire_req[k]) mPend[k] = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (modelOn) begin
      check("grant", grant, mGrant);
      check("launch", launch, mLaunch);
      check("grant_slot", grant_slot, mSlot);
      check("slot_busy", slot_busy, busy_vec());
      check("free_count", free_count, free_slots());
      check("state", dbgState, mScan);
      check("rr_ptr", dbgRrPtr, mRr);
      if (launch) obs_q.push_back({grant, grant_slot});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    resetN = 1'b0; startOfFrame = 1'b0; fire_req = '0; slot_release = '0;
    tick(2);
    resetN = 1'b1;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic pulse_fire(input logic [NR-1:0] v);
    fire_req = v;
    tick(1);
    fire_req = '0;
  endtask

  task automatic pulse_release(input logic [NS-1:0] v);
    slot_release = v;
    tick(1);
    slot_release = '0;
  endtask

  task automatic run_frame();
    startOfFrame = 1'b1;
    tick(1);
    startOfFrame = 1'b0;
    tick(8);
  endtask

  task automatic check_log(input string name);
    int n;
    check({name, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({name, "_entry"}, obs_q[i], exp_q[i]);
    exp_q.delete();
    obs_q.delete();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    bit seen;
    resetN = 1'b0; startOfFrame = 1'b0; fire_req = '0; slot_release = '0;
    @(negedge clk);

    // 1: reset
    do_reset();
    check("t1_grant", grant, 4'b0000);
    check("t1_launch", launch, 1'b0);
    check("t1_slot_busy", slot_busy, 8'h00);
    check("t1_free_count", free_count, 4'd8);

    // 2: single request, latency
    pulse_fire(4'b0001);
    startOfFrame = 1'b1;
    tick(1);
    startOfFrame = 1'b0;
    check("t2_launch_t1", launch, 1'b0);
    tick(1);
    check("t2_launch_t2", launch, 1'b1);
    check("t2_grant_t2", grant, 4'b0001);
    check("t2_slot_t2", grant_slot, 3'd0);
    tick(1);
    check("t2_launch_t3", launch, 1'b0);
    check("t2_slot_busy", slot_busy, 8'h01);
    check("t2_free_count", free_count, 4'd7);
    tick(6);
    exp_q.push_back({4'b0001, 3'd0});
    check_log("t2_log");

    // 3: round-robin across two frames
    do_reset();
    pulse_fire(4'b0110);
    exp_q.push_back({4'b0010, 3'd0});
    exp_q.push_back({4'b0100, 3'd1});
    run_frame();
    check_log("t3a_log");
    pulse_fire(4'b1111);
    exp_q.push_back({4'b1000, 3'd2});
    exp_q.push_back({4'b0001, 3'd3});
    exp_q.push_back({4'b0010, 3'd4});
    exp_q.push_back({4'b0100, 3'd5});
    run_frame();
    check_log("t3b_log");
    check("t3_slot_busy", slot_busy, 8'h3F);
    check("t3_free_count", free_count, 4'd2);

    // 4: pool full, pending kept, release then grant
    do_reset();
    pulse_fire(4'b1111);
    run_frame();
    pulse_fire(4'b1111);
    run_frame();
    for (int i = 0; i < 8; i++) exp_q.push_back({4'(1 << (i % 4)), 3'(i)});
    check_log("t4_fill_log");
    check("t4_slot_busy_full", slot_busy, 8'hFF);
    check("t4_free_count_full", free_count, 4'd0);
    pulse_fire(4'b0001);
    run_frame();
    check_log("t4_full_log");
    pulse_release(8'h20);
    check("t4_slot_busy_rel", slot_busy, 8'hDF);
    exp_q.push_back({4'b0001, 3'd5});
    run_frame();
    check_log("t4_after_rel_log");

    // 5: repeated pulses merge into one grant
    do_reset();
    pulse_fire(4'b0100);
    tick(1);
    pulse_fire(4'b0100);
    tick(1);
    pulse_fire(4'b0100);
    exp_q.push_back({4'b0100, 3'd0});
    run_frame();
    check_log("t5_frame1_log");
    run_frame();
    check_log("t5_frame2_log");

    // 6: reset during a scan
    do_reset();
    pulse_fire(4'b1111);
    startOfFrame = 1'b1;
    tick(1);
    startOfFrame = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick(1);
      if (launch) seen = 1'b1;
    end
    check("t6_first_grant_seen", seen, 1'b1);
    resetN = 1'b0;
    tick(1);
    check("t6_grant", grant, 4'b0000);
    check("t6_launch", launch, 1'b0);
    check("t6_slot_busy", slot_busy, 8'h00);
    check("t6_rr_ptr", dbgRrPtr, 2'd0);
    check("t6_state", dbgState, 1'b0);
    tick(1);
    resetN = 1'b1;
    tick(6);
    exp_q.push_back({4'b0001, 3'd0});
    check_log("t6_log");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
